// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between execute (port 0) and branch (port 1).
// Defining ALU_ARB_STATS_EN adds per-port grant counters and a saturating conflict counter.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DATA_WIDTH-1:0] req_src1_0,
    input  logic [DATA_WIDTH-1:0] req_src2_0,
    input  logic [DATA_WIDTH-1:0] req_src1_1,
    input  logic [DATA_WIDTH-1:0] req_src2_1,
    input  logic [2:0]            req_ctrl_0,
    input  logic [2:0]            req_ctrl_1,
    output logic [DATA_WIDTH-1:0] alu_src1,
    output logic [DATA_WIDTH-1:0] alu_src2,
    output logic [2:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_eq,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_eq
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]           grant_cnt_0,
    output logic [15:0]           grant_cnt_1,
    output logic [15:0]           conflict_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] src1_q, src1_d;
    logic [DATA_WIDTH-1:0] src2_q, src2_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  eq_q, eq_d;
    logic [1:0]            grant;
    logic                  sel;
    logic                  accept;

    // last_q names the previous winner; on a tie the other port is granted
    assign grant  = (req_valid == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req_valid;
    assign sel    = grant[1];
    assign accept = (state_q == IDLE) && (grant != 2'b00);

    assign req_ready  = (state_q == IDLE && rst_n) ? grant : 2'b00;
    assign rsp_valid  = (state_q == RESP) ? {owner_q, ~owner_q} : 2'b00;
    assign rsp_result = result_q;
    assign rsp_eq     = eq_q;
    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign alu_ctrl   = ctrl_q;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        eq_d     = eq_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    owner_d = sel;
                    last_d  = sel;
                    src1_d  = sel ? req_src1_1 : req_src1_0;
                    src2_d  = sel ? req_src2_1 : req_src2_0;
                    ctrl_d  = sel ? req_ctrl_1 : req_ctrl_0;
                end
            end
            ISSUE: begin
                result_d = alu_result;
                eq_d     = alu_eq;
                state_d  = RESP;
            end
            RESP:    state_d = rsp_ready[owner_q] ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            eq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            eq_q     <= eq_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gcnt0_q, gcnt1_q, conf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            conf_q  <= '0;
        end else begin
            if (accept && !sel) gcnt0_q <= gcnt0_q + 16'd1;
            if (accept && sel) gcnt1_q <= gcnt1_q + 16'd1;
            if (accept && req_valid == 2'b11 && conf_q != 16'hFFFF) conf_q <= conf_q + 16'd1;
        end
    end

    assign grant_cnt_0  = gcnt0_q;
    assign grant_cnt_1  = gcnt1_q;
    assign conflict_cnt = conf_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven and scoreboard bench for alu_arbiter with a behavioural ALU on its ALU ports.
module tb_alu_arbiter;
    localparam int DW = 32;

    typedef struct packed {
        logic          port;
        logic [2:0]    ctrl;
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        logic [DW-1:0] res;
        logic          eq;
    } vec_t;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] res;
        logic          eq;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [DW-1:0] req_src1_0, req_src2_0, req_src1_1, req_src2_1;
    logic [2:0]    req_ctrl_0, req_ctrl_1, alu_ctrl;
    logic [DW-1:0] alu_src1, alu_src2, alu_result, rsp_result;
    logic          alu_eq, rsp_eq;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]   grant_cnt_0, grant_cnt_1, conflict_cnt;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t cur_exp[2];
    int   grant_log[$];
    logic mon_p;
    exp_t mon_e;
    vec_t vecs[8];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1_0(req_src1_0), .req_src2_0(req_src2_0),
        .req_src1_1(req_src1_1), .req_src2_1(req_src2_1),
        .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_eq(alu_eq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_eq(rsp_eq)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1), .conflict_cnt(conflict_cnt)
`endif
    );

    // Behavioural stand-in for the shared combinational ALU
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_src1 + alu_src2;
            3'b001:  alu_result = alu_src1 - alu_src2;
            3'b010:  alu_result = alu_src1 & alu_src2;
            3'b011:  alu_result = alu_src1 | alu_src2;
            3'b101:  alu_result = {{(DW-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
            default: alu_result = '0;
        endcase
    end
    assign alu_eq = (alu_src1 == alu_src2);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic set_port(input logic p, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                            input logic [2:0] c, input logic [DW-1:0] r, input logic e);
        if (p) begin
            req_src1_1 = s1; req_src2_1 = s2; req_ctrl_1 = c;
        end else begin
            req_src1_0 = s1; req_src2_0 = s2; req_ctrl_0 = c;
        end
        cur_exp[p] = '{p, r, e};
    endtask

    task automatic wait_accept(input logic p, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[p] && n < 40);
        if (!req_ready[p]) timeout(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((sb.size() != 0 || rsp_valid != 2'b00) && n < 40);
        if (sb.size() != 0 || rsp_valid != 2'b00) begin
            timeout(nm);
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        set_port(v.port, v.s1, v.s2, v.ctrl, v.res, v.eq);
        req_valid[v.port] = 1'b1;
        wait_accept(v.port, nm);
        req_valid[v.port] = 1'b0;
        wait_idle(nm);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req_ready"}, req_ready, 0);
        chk({nm, "_rsp_valid"}, rsp_valid, 0);
        chk({nm, "_alu_src1"}, alu_src1, 0);
        chk({nm, "_alu_src2"}, alu_src2, 0);
        chk({nm, "_alu_ctrl"}, alu_ctrl, 0);
        chk({nm, "_rsp_result"}, rsp_result, 0);
        chk({nm, "_rsp_eq"}, rsp_eq, 0);
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (|(req_valid & req_ready)) begin
                mon_p = req_ready[1];
                chk("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
                grant_log.push_back(int'(mon_p));
                sb.push_back(cur_exp[mon_p]);
            end
            if (|(rsp_valid & rsp_ready)) begin
                if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("rsp_valid_route", rsp_valid, mon_e.port ? 2'b10 : 2'b01);
                    chk("rsp_result", rsp_result, mon_e.res);
                    chk("rsp_eq", rsp_eq, mon_e.eq);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int tie_exp[4] = '{0, 1, 0, 1};
        int n;
        vecs[0] = '{1'b0, 3'b001, 32'd10, 32'd3, 32'd7, 1'b0};
        vecs[1] = '{1'b1, 3'b010, 32'hF0, 32'h3C, 32'h30, 1'b0};
        vecs[2] = '{1'b0, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
        vecs[3] = '{1'b1, 3'b001, 32'h55, 32'h55, 32'd0, 1'b1};
        vecs[4] = '{1'b1, 3'b011, 32'h0F, 32'hF0, 32'hFF, 1'b0};
        vecs[5] = '{1'b0, 3'b101, 32'd3, 32'd5, 32'd1, 1'b0};
        vecs[6] = '{1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0};
        vecs[7] = '{1'b0, 3'b100, 32'd9, 32'd9, 32'd0, 1'b1};

        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst_n = 1'b1;

        // Tie from reset: grants alternate starting with port 0
        set_port(0, 32'd10, 32'd3, 3'b001, 32'd7, 1'b0);
        set_port(1, 32'hF0, 32'h3C, 3'b010, 32'h30, 1'b0);
        rsp_ready = 2'b11;
        grant_log.delete();
        req_valid = 2'b11;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (grant_log.size() < 4 && n < 40);
        req_valid = 2'b00;
        if (grant_log.size() < 4) timeout("tie_grants");
        else for (int i = 0; i < 4; i++) chk($sformatf("tie_grant%0d", i), grant_log[i], tie_exp[i]);
        wait_idle("tie_drain");

        // Single op with exact latency
        set_port(0, 32'd7, 32'd5, 3'b000, 32'd12, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("single_req_ready", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("issue_rsp_valid", rsp_valid, 2'b00);
        chk("issue_req_ready", req_ready, 2'b00);
        chk("issue_alu_src1", alu_src1, 32'd7);
        chk("issue_alu_src2", alu_src2, 32'd5);
        chk("issue_alu_ctrl", alu_ctrl, 3'b000);
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 2'b01);
        wait_idle("single_drain");

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure on port 1; non-owner rsp_ready must not release it
        set_port(1, 32'h0F, 32'hF0, 3'b011, 32'hFF, 1'b0);
        set_port(0, 32'd1, 32'd2, 3'b000, 32'd3, 1'b0);
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        wait_accept(1, "bp_accept1");
        req_valid = 2'b01;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_rsp_valid%0d", i), rsp_valid, 2'b10);
            chk($sformatf("bp_rsp_result%0d", i), rsp_result, 32'hFF);
            chk($sformatf("bp_req_ready%0d", i), req_ready, 2'b00);
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        wait_accept(0, "bp_accept0");
        req_valid = 2'b00;
        wait_idle("bp_drain");

        // Reset during ISSUE drops the op; next tie goes to port 0
        set_port(0, 32'd4, 32'd4, 3'b000, 32'd8, 1'b1);
        req_valid = 2'b01;
        wait_accept(0, "rst_accept");
        set_port(1, 32'd6, 32'd2, 3'b001, 32'd4, 1'b0);
        req_valid = 2'b11;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_tie_grant", req_ready, 2'b01);
        chk("postrst_rsp_valid", rsp_valid, 2'b00);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle("postrst_drain");

`ifdef ALU_ARB_STATS_EN
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("stats_rst_g0", grant_cnt_0, 0);
        chk("stats_rst_conf", conflict_cnt, 0);
        set_port(0, 32'd1, 32'd1, 3'b000, 32'd2, 1'b1);
        set_port(1, 32'd2, 32'd1, 3'b001, 32'd1, 1'b0);
        grant_log.delete();
        req_valid = 2'b11;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (grant_log.size() < 2 && n < 40);
        req_valid = 2'b00;
        if (grant_log.size() < 2) timeout("stats_ties");
        wait_idle("stats_tie_drain");
        run_vec(vecs[0], "stats_p0a");
        run_vec(vecs[2], "stats_p0b");
        run_vec(vecs[1], "stats_p1");
        chk("stats_grant_cnt_0", grant_cnt_0, 16'd3);
        chk("stats_grant_cnt_1", grant_cnt_1, 16'd2);
        chk("stats_conflict_cnt", conflict_cnt, 16'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
